// File: rtl/vgafb_fetch.sv
// ----------------------------------------------------------------------------
// vgafb_fetch
//
// Upstream feeder for the 64-to-16 pixel FIFO of the VGA framebuffer. Walks
// the framebuffer linearly with 4-beat (32-byte) FML read bursts. Each burst
// pushes its four 64-bit beats into the FIFO, and the walk wraps at end of
// frame. A new framebuffer base is only taken at a frame boundary, so software
// can flip buffers without tearing.
//
// Ports
//   sys_clk          system clock
//   vga_rst          asynchronous, active-high reset
//   enable           allow new bursts (an in-flight burst always completes)
//   baseaddress      framebuffer start, bits [4:0] ignored
//   nbursts          bursts per frame, 0 behaves as 1
//   fml_adr          burst address, bits [4:0] always 0
//   fml_stb          burst request, held until fml_ack
//   fml_ack          request accepted by the memory controller
//   fml_di           read data, 4 beats starting the cycle after fml_ack
//   can_burst        FIFO has room for 4 more 64-bit words
//   fifo_stb         FIFO write strobe
//   fifo_di          FIFO write data
//   frame_start      one-cycle pulse with the first request of a frame
//   baseaddress_act  base address of the frame currently being fetched
// ----------------------------------------------------------------------------
module vgafb_fetch #(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 vga_rst,
    input  logic                 enable,
    input  logic [fml_depth-1:0] baseaddress,
    input  logic [17:0]          nbursts,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    input  logic                 fml_ack,
    input  logic [63:0]          fml_di,
    input  logic                 can_burst,
    output logic                 fifo_stb,
    output logic [63:0]          fifo_di,
    output logic                 frame_start,
    output logic [fml_depth-1:0] baseaddress_act
);

    localparam int AW = fml_depth - 5;

    // Clears the byte-within-burst bits of an address.
    localparam logic [fml_depth-1:0] ALIGN_MASK = {{AW{1'b1}}, 5'b00000};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DATA0 = 3'd2,
        DATA1 = 3'd3,
        DATA2 = 3'd4,
        DATA3 = 3'd5
    } state_t;

    state_t                 state_r;
    logic [17:0]            count_r;
    logic [17:0]            last_s;
    logic [fml_depth-1:0]   base_aligned_s;
    logic [fml_depth-1:0]   base_sel_s;
    logic [fml_depth-1:0]   burst_adr_s;

    // Last burst index of the frame, base for the next request and its address.
    always_comb begin
        if (nbursts == 18'd0) begin
            last_s = 18'd0;
        end else begin
            last_s = nbursts - 18'd1;
        end

        base_aligned_s = baseaddress & ALIGN_MASK;

        // At the start of a frame the freshly latched base must already be
        // used for the first address, so bypass baseaddress_act.
        if (count_r == 18'd0) begin
            base_sel_s = base_aligned_s;
        end else begin
            base_sel_s = baseaddress_act;
        end

        // Both operands have zero low bits, so the full-width sum truncated to
        // fml_depth wraps modulo the FML space and keeps bits [4:0] at zero.
        burst_adr_s = base_sel_s + {AW'(count_r), 5'b00000};
    end

    // Burst sequencer with registered FML and FIFO outputs.
    always_ff @(posedge sys_clk or posedge vga_rst) begin
        if (vga_rst) begin
            state_r         <= IDLE;
            count_r         <= 18'd0;
            fml_adr         <= {fml_depth{1'b0}};
            fml_stb         <= 1'b0;
            fifo_stb        <= 1'b0;
            fifo_di         <= 64'd0;
            frame_start     <= 1'b0;
            baseaddress_act <= {fml_depth{1'b0}};
        end else begin
            frame_start <= 1'b0;
            fifo_stb    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable && can_burst) begin
                        state_r <= REQ;
                        fml_stb <= 1'b1;
                        fml_adr <= burst_adr_s;
                        if (count_r == 18'd0) begin
                            baseaddress_act <= base_aligned_s;
                            frame_start     <= 1'b1;
                        end else begin
                            baseaddress_act <= baseaddress_act;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // enable/can_burst are deliberately ignored once requested.
                    if (fml_ack) begin
                        fml_stb <= 1'b0;
                        state_r <= DATA0;
                    end else begin
                        state_r <= REQ;
                    end
                end
                DATA0: begin
                    fifo_stb <= 1'b1;
                    fifo_di  <= fml_di;
                    state_r  <= DATA1;
                end
                DATA1: begin
                    fifo_stb <= 1'b1;
                    fifo_di  <= fml_di;
                    state_r  <= DATA2;
                end
                DATA2: begin
                    fifo_stb <= 1'b1;
                    fifo_di  <= fml_di;
                    state_r  <= DATA3;
                end
                DATA3: begin
                    fifo_stb <= 1'b1;
                    fifo_di  <= fml_di;
                    // Always pass through IDLE so can_burst reflects these
                    // four writes before the next decision.
                    state_r  <= IDLE;
                    if (count_r == last_s) begin
                        count_r <= 18'd0;
                    end else begin
                        count_r <= count_r + 18'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    fml_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vgafb_fetch.sv
`timescale 1ns/1ps
module tb_vgafb_fetch;

    localparam int FD = 26;

    logic          sys_clk = 1'b0;
    logic          vga_rst = 1'b1;
    logic          enable = 1'b0;
    logic [FD-1:0] baseaddress = '0;
    logic [17:0]   nbursts = 18'd0;
    logic          fml_ack = 1'b0;
    logic [63:0]   fml_di = 64'd0;
    logic          can_burst = 1'b0;
    logic [FD-1:0] fml_adr;
    logic          fml_stb;
    logic          fifo_stb;
    logic [63:0]   fifo_di;
    logic          frame_start;
    logic [FD-1:0] baseaddress_act;

    vgafb_fetch #(.fml_depth(FD)) dut (
        .sys_clk(sys_clk), .vga_rst(vga_rst), .enable(enable),
        .baseaddress(baseaddress), .nbursts(nbursts),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_ack(fml_ack),
        .fml_di(fml_di), .can_burst(can_burst),
        .fifo_stb(fifo_stb), .fifo_di(fifo_di),
        .frame_start(frame_start), .baseaddress_act(baseaddress_act)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model (transaction level) ----------------
    // Frame position m_cnt, active base m_act; a burst occupies the edges up
    // to 4 after its ack, the next request decision is at the edge after that.
    int unsigned   m_cnt;
    logic [FD-1:0] m_act;
    bit            m_req;
    logic [FD-1:0] m_adr;
    bit            m_fs;
    bit            m_ackd;
    bit            m_wr;
    logic [63:0]   m_di;
    longint        edge_n;
    longint        ack_edge;

    always @(posedge sys_clk or posedge vga_rst) begin
        if (vga_rst) begin
            m_cnt = 0; m_act = '0; m_req = 0; m_adr = '0; m_fs = 0;
            m_ackd = 0; m_wr = 0; m_di = 64'd0; edge_n = 0; ack_edge = 0;
        end else begin
            edge_n++;
            m_fs = 0;
            m_wr = m_ackd && (edge_n > ack_edge) && (edge_n <= ack_edge + 4);
            if (m_wr) m_di = fml_di;
            if (m_ackd && edge_n == ack_edge + 4)
                m_cnt = (m_cnt + 1) % ((nbursts == 18'd0) ? 1 : int'(nbursts));
            if (m_req) begin
                if (fml_ack) begin
                    m_req = 0; m_ackd = 1; ack_edge = edge_n;
                end
            end else if (!(m_ackd && edge_n <= ack_edge + 4) && enable && can_burst) begin
                if (m_cnt == 0) begin
                    m_act = baseaddress & ~26'h1F;
                    m_fs = 1;
                end
                m_adr = FD'((longint'(m_act) + longint'(m_cnt) * 32) % (longint'(1) << FD));
                m_req = 1;
            end
        end
    end

    // ---------------- Compare process + logs ----------------
    logic [FD-1:0] adr_log[$];
    bit            fs_log[$];
    logic [63:0]   wr_log[$];
    bit            prev_stb = 0;

    always @(negedge sys_clk) begin
        chk("fml_stb", fml_stb, m_req);
        if (m_req) chk("fml_adr", fml_adr, m_adr);
        chk("frame_start", frame_start, m_fs);
        chk("fifo_stb", fifo_stb, m_wr);
        if (m_wr) chk("fifo_di", fifo_di, m_di);
        chk("baseaddress_act", baseaddress_act, m_act);
        if (fml_stb && !prev_stb) begin
            adr_log.push_back(fml_adr);
            fs_log.push_back(frame_start);
        end
        if (fifo_stb) wr_log.push_back(fifo_di);
        prev_stb = fml_stb;
    end

    // ---------------- Memory controller responder ----------------
    int lat = 3;
    int wcnt = 0;
    int beats_left = 0;
    int beat_idx = 0;
    bit rand_data = 0;

    always @(negedge sys_clk) begin
        if (vga_rst) begin
            fml_ack = 1'b0; wcnt = 0; beats_left = 0;
        end else begin
            if (fml_ack) begin
                fml_ack = 1'b0; beats_left = 4; beat_idx = 0; wcnt = 0;
            end
            if (beats_left > 0) begin
                fml_di = rand_data ? {$urandom, $urandom} : 64'(beat_idx);
                beat_idx++;
                beats_left--;
            end else if (fml_stb) begin
                wcnt++;
                if (wcnt >= lat) fml_ack = 1'b1;
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_logs();
        adr_log.delete(); fs_log.delete(); wr_log.delete();
    endtask

    task automatic do_reset(input logic [FD-1:0] base, input logic [17:0] nb);
        vga_rst = 1'b1;
        baseaddress = base;
        nbursts = nb;
        clear_logs();
        tick(); tick();
        vga_rst = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int k = 0;
        while (adr_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("request_count", adr_log.size(), n);
    endtask

    task automatic wait_fifo_stb(input int budget);
        int k = 0;
        while (!fifo_stb && k < budget) begin
            tick();
            k++;
        end
        chk("fifo_stb_seen", fifo_stb, 1'b1);
    endtask

    // ---------------- Test sequence ----------------
    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_fml_stb", fml_stb, 1'b0);
        chk("rst_fml_adr", fml_adr, 64'd0);
        chk("rst_fifo_stb", fifo_stb, 1'b0);
        chk("rst_fifo_di", fifo_di, 64'd0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_base_act", baseaddress_act, 64'd0);

        // Basic burst sequence
        rand_data = 0; lat = 3;
        enable = 1'b1; can_burst = 1'b1;
        do_reset(26'h0100000, 18'd4);
        wait_reqs(5, 200);
        chk("basic_adr0", adr_log[0], 64'h100000);
        chk("basic_adr1", adr_log[1], 64'h100020);
        chk("basic_adr2", adr_log[2], 64'h100040);
        chk("basic_adr3", adr_log[3], 64'h100060);
        chk("basic_adr4", adr_log[4], 64'h100000);
        chk("basic_fs0", fs_log[0], 1'b1);
        chk("basic_fs1", fs_log[1], 1'b0);
        chk("basic_fs4", fs_log[4], 1'b1);
        for (int i = 0; i < 4; i++) chk("basic_fifo_di", wr_log[i], 64'(i));

        // Backpressure
        can_burst = 1'b0;
        do_reset(26'h0100000, 18'd4);
        repeat (20) tick();
        chk("bp_no_request", adr_log.size(), 0);
        can_burst = 1'b1;
        @(posedge sys_clk); #1;
        chk("bp_stb_next_edge", fml_stb, 1'b1);
        wait_fifo_stb(50);
        can_burst = 1'b0;       // now in DATA1
        repeat (15) tick();
        chk("bp_writes", wr_log.size(), 4);
        chk("bp_one_request", adr_log.size(), 1);
        can_burst = 1'b1;

        // Buffer flip mid-frame
        do_reset(26'h0100000, 18'd4);
        wait_reqs(2, 100);
        baseaddress = 26'h0200000;
        wait_reqs(5, 200);
        chk("flip_adr2", adr_log[2], 64'h100040);
        chk("flip_adr3", adr_log[3], 64'h100060);
        chk("flip_adr4", adr_log[4], 64'h200000);
        chk("flip_fs4", fs_log[4], 1'b1);
        chk("flip_base_act", baseaddress_act, 64'h200000);

        // Enable gating during REQ
        do_reset(26'h0100000, 18'd8);
        wait_reqs(3, 150);
        enable = 1'b0;
        repeat (30) tick();
        chk("en_stays_idle", adr_log.size(), 3);
        chk("en_writes", wr_log.size(), 12);
        enable = 1'b1;
        wait_reqs(4, 50);
        chk("en_resume_adr", adr_log[3], 64'h100060);
        chk("en_resume_fs", fs_log[3], 1'b0);

        // Asynchronous reset during DATA2
        do_reset(26'h0100000, 18'd4);
        wait_reqs(1, 50);
        wait_fifo_stb(50);      // in DATA1
        @(posedge sys_clk);     // now in DATA2
        #2 vga_rst = 1'b1;
        #1;
        chk("arst_fml_stb", fml_stb, 1'b0);
        chk("arst_fifo_stb", fifo_stb, 1'b0);
        chk("arst_frame_start", frame_start, 1'b0);
        chk("arst_base_act", baseaddress_act, 64'd0);
        baseaddress = 26'h0300000;
        tick(); tick();
        clear_logs();
        vga_rst = 1'b0;
        wait_reqs(1, 50);
        chk("arst_first_adr", adr_log[0], 64'h300000);
        chk("arst_first_fs", fs_log[0], 1'b1);

        // nbursts = 0 behaves as 1
        do_reset(26'h0123460, 18'd0);
        wait_reqs(3, 150);
        for (int i = 0; i < 3; i++) begin
            chk("nb0_adr", adr_log[i], 64'h123460);
            chk("nb0_fs", fs_log[i], 1'b1);
        end

        // Address wrap modulo the FML space
        do_reset(26'h3FFFFE0, 18'd2);
        wait_reqs(3, 150);
        chk("wrap_adr0", adr_log[0], 64'h3FFFFE0);
        chk("wrap_adr1", adr_log[1], 64'h0000000);
        chk("wrap_fs1", fs_log[1], 1'b0);
        chk("wrap_adr2", adr_log[2], 64'h3FFFFE0);
        chk("wrap_fs2", fs_log[2], 1'b1);

        // Randomized traffic against the model
        rand_data = 1;
        for (int c = 0; c < 4; c++) begin
            do_reset(FD'({$urandom} & 32'h03FF_FFE7), 18'($urandom_range(0, 5)));
            for (int k = 0; k < 300; k++) begin
                enable    = ($urandom_range(0, 9) < 8);
                can_burst = ($urandom_range(0, 9) < 7);
                lat       = $urandom_range(1, 4);
                if ($urandom_range(0, 49) == 0) baseaddress = FD'($urandom);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/vgafb_fetch.md
Name: vgafb_fetch

Overview:
- Upstream feeder for the 64-to-16 pixel FIFO.
- Issues 4-beat FML read bursts (32 bytes each) across the framebuffer in linear order.
- Pushes each 64-bit beat into the FIFO and wraps at end of frame.
- Latches a new base address only at frame boundaries, so software can flip buffers tear-free.

Parameters:
fml_depth, 26, FML byte-address width.

Ports:
sys_clk  in  1  system clock.
vga_rst  in  1  reset, asynchronous, active-high.
enable  in  1  allow new bursts; an in-flight burst always completes.
baseaddress  in  fml_depth  framebuffer start; bits [4:0] ignored (32-byte aligned).
nbursts  in  18  bursts per frame (hres*vres*2/32); 0 treated as 1.
fml_adr  out  fml_depth  burst address, bits [4:0] always 0.
fml_stb  out  1  burst request.
fml_ack  in  1  request accepted.
fml_di  in  64  read data.
can_burst  in  1  FIFO has room for 4 more 64-bit words.
fifo_stb  out  1  write strobe into FIFO.
fifo_di  out  64  data to FIFO.
frame_start  out  1  one-cycle pulse when a frame's first burst is requested.
baseaddress_act  out  fml_depth  base address of the frame currently being fetched.

Behaviour:
- Reset is asynchronous, active-high. Every output is 0, the state is IDLE, and the burst counter is 0.
- Base handling while in reset:
  - baseaddress_act = 0 while reset is asserted.
  - The first burst after release latches baseaddress.
- States: IDLE, REQ, DATA0, DATA1, DATA2, DATA3.
- IDLE:
  - If enable & can_burst, go to REQ and assert fml_stb.
  - If the burst counter = 0, latch baseaddress[fml_depth-1:5] into baseaddress_act and pulse frame_start for that cycle.
  - fml_adr = {baseaddress_act[fml_depth-1:5] + count, 5'b0}. When the counter is 0, the newly latched base is used.
  - The addition is truncated to fml_depth-5 bits, so the address wraps modulo the FML space.
- REQ:
  - Hold fml_stb = 1, with fml_adr stable, until fml_ack.
  - On fml_ack, deassert fml_stb the next cycle and go to DATA0.
  - enable and can_burst are not re-sampled in this state.
- DATA0..DATA3:
  - The beat arrives on fml_di on the cycle after ack and on the 3 consecutive cycles that follow.
  - Each DATA cycle registers fml_di into fifo_di and asserts fifo_stb for one cycle. The FIFO therefore sees 4 consecutive writes, lagging the FML beats by 1 cycle.
- Leaving DATA3:
  - If count = max(nbursts,1)-1, count becomes 0; otherwise count+1.
  - Return to IDLE.
- IDLE is always spent for at least 1 cycle between bursts. This makes the FIFO level updated by the 4 writes visible on can_burst before the next decision.
- Peak throughput is 1 burst per 6 cycles plus ack wait.
- nbursts is sampled at end of each burst. If it is shrunk below the current count, the wrap occurs when count+1 overflows 18 bits or next matches. Software must only change nbursts with enable low and then pulse vga_rst.
- enable dropping in REQ/DATA: the burst finishes with all 4 FIFO writes, then the block waits in IDLE. The counter is retained, and fetch resumes mid-frame when enable returns.
- Reset mid-burst aborts immediately: fml_stb and fifo_stb go to 0. The memory controller tolerates an abandoned request.
- The block never writes to the FIFO outside DATA states, so there are exactly 4 fifo_stb per fml_ack.

Test Plan:
- Basic burst: base=0x100000, nbursts=4, can_burst=1, ack 3 cycles after stb, data=beat index.
  - fml_adr = 0x100000, 0x100020, 0x100040, 0x100060, then 0x100000.
  - frame_start pulses on the 1st and 5th requests.
  - 4 fifo_stb per ack, with fifo_di = 0,1,2,3 in order.
- Backpressure: can_burst=0.
  - fml_stb stays 0 indefinitely.
  - can_burst rising while in IDLE gives fml_stb=1 on the next edge.
  - can_burst falling during DATA1 does not cut the burst (still 4 writes).
- Buffer flip: change baseaddress to 0x200000 while count=2 of nbursts=4.
  - Bursts 2 and 3 still use the old base.
  - The next frame starts at 0x200000, and baseaddress_act updates with frame_start.
- Enable gating: drop enable during REQ.
  - The burst completes with 4 writes, then the block stays idle.
  - Re-enabling resumes at count+1's address, not the frame start.
- Async reset during DATA2: assert vga_rst between clock edges.
  - fml_stb, fifo_stb and frame_start go to 0 before the next edge.
  - After release, the first request is at the current baseaddress with frame_start=1.
- nbursts=0 and address wrap:
  - nbursts=0 behaves as 1: every request is at the base with frame_start.
  - base=0x3FFFFE0 with nbursts=2: the second address wraps to 0x0000000.
